logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the two-input gate block. It applies one of seven bitwise logic operations, selected per transaction by an opcode, to two WIDTH-bit operands. Operands enter and results leave through valid/ready handshakes, with full backpressure. It sits as a datapath element between a producer and a consumer stream in the same clock domain.

---
 rtl/logic_unit_pipe.sv | 158 +++++++++++++++
 tb/tb_logic_unit_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready pipelined bitwise logic unit
//
// Purpose: applies one of seven bitwise operations (op 7 flags an error) to
// two WIDTH-bit operands. S1 captures the operands and S2 registers the
// result and its flags. Both stages stall under backpressure, so the unit
// holds at most two transactions.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for a, b, op
//   a, b, op            operands and opcode (0 AND,1 OR,2 NOT a,3 NAND,
//                       4 NOR,5 XOR,6 XNOR,7 illegal)
//   out_valid/out_ready output handshake for y and flags
//   y, y_zero, y_parity result, result==0, XOR-reduction of result
//   y_err               result came from op 7
//   acc_count           saturating count of accepted inputs
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_parity,
  output logic             y_err,
  output logic [CNT_W-1:0] acc_count
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_zero_q, y_zero_d;
  logic             y_parity_q, y_parity_d;
  logic             y_err_q, y_err_d;
  logic [CNT_W-1:0] acc_q, acc_d;

  logic             s2_load;
  logic             in_fire;
  logic [WIDTH-1:0] res;
  logic             res_err;

  // S2 is free when empty or its result leaves this cycle; S1 can take a new
  // input when empty or when its content moves into S2. This is the only
  // combinational path from an input (out_ready) to an output (in_ready).
  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (s1_op_q)
      OP_AND:  res = s1_a_q & s1_b_q;
      OP_OR:   res = s1_a_q | s1_b_q;
      OP_NOT:  res = ~s1_a_q;
      OP_NAND: res = ~(s1_a_q & s1_b_q);
      OP_NOR:  res = ~(s1_a_q | s1_b_q);
      OP_XOR:  res = s1_a_q ^ s1_b_q;
      OP_XNOR: res = ~(s1_a_q ^ s1_b_q);
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    // When in_ready is high S1 is either empty or draining into S2, so its
    // valid bit simply follows in_valid.
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = a;
        s1_b_d  = b;
        s1_op_d = op;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    y_zero_d    = y_zero_q;
    y_parity_d  = y_parity_q;
    y_err_d     = y_err_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d        = res;
        y_zero_d   = ~|res;
        y_parity_d = ^res;
        y_err_d    = res_err;
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (in_fire && (acc_q != {CNT_W{1'b1}})) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_zero_q    <= 1'b0;
      y_parity_q  <= 1'b0;
      y_err_q     <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      y_zero_q    <= y_zero_d;
      y_parity_q  <= y_parity_d;
      y_err_q     <= y_err_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign y_zero    = y_zero_q;
  assign y_parity  = y_parity_q;
  assign y_err     = y_err_q;
  assign acc_count = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;

  logic clk;
  int   n_cmp = 0;
  int   n_bad = 0;

  // DUT 0: WIDTH 8, CNT_W 16
  logic        rst_n0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [7:0]  a0, b0, y0;
  logic [2:0]  op0;
  logic        y_zero0, y_parity0, y_err0;
  logic [15:0] acc_count0;

  // DUT 1: WIDTH 13, CNT_W 4
  logic        rst_n1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [12:0] a1, b1, y1;
  logic [2:0]  op1;
  logic        y_zero1, y_parity1, y_err1;
  logic [3:0]  acc_count1;

  logic [18:0] q0[$];
  logic [18:0] q1[$];
  logic [18:0] e0, e1;
  int          n_push1 = 0;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n0), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .op(op0), .out_valid(out_valid0), .out_ready(out_ready0),
    .y(y0), .y_zero(y_zero0), .y_parity(y_parity0), .y_err(y_err0),
    .acc_count(acc_count0)
  );

  logic_unit_pipe #(.WIDTH(13), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1),
    .y(y1), .y_zero(y_zero1), .y_parity(y_parity1), .y_err(y_err1),
    .acc_count(acc_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {err, parity, zero, y[15:0]}.
  function automatic logic [18:0] model(input int w, input logic [2:0] op,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [15:0] m;
    logic        err;
    m   = 16'((32'd1 << w) - 1);
    err = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~a;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = a ^ b;
      3'd6: r = ~(a ^ b);
      default: begin r = 16'h0; err = 1'b1; end
    endcase
    r = r & m;
    return {err, ^r, (r == 16'h0), r};
  endfunction

  always @(negedge clk) begin
    if (rst_n0) begin
      if (out_valid0 && out_ready0) begin
        check("d0_sb_has_item", 32'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          check("d0_y", 32'(y0), 32'(e0[7:0]));
          check("d0_zero", 32'(y_zero0), 32'(e0[16]));
          check("d0_parity", 32'(y_parity0), 32'(e0[17]));
          check("d0_err", 32'(y_err0), 32'(e0[18]));
        end
      end
      if (in_valid0 && in_ready0) q0.push_back(model(8, op0, {8'h0, a0}, {8'h0, b0}));
    end
  end

  always @(negedge clk) begin
    if (rst_n1) begin
      if (out_valid1 && out_ready1) begin
        check("d1_sb_has_item", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          check("d1_y", 32'(y1), 32'(e1[12:0]));
          check("d1_zero", 32'(y_zero1), 32'(e1[16]));
          check("d1_parity", 32'(y_parity1), 32'(e1[17]));
          check("d1_err", 32'(y_err1), 32'(e1[18]));
        end
      end
      if (in_valid1 && in_ready1) begin
        q1.push_back(model(13, op1, {3'h0, a1}, {3'h0, b1}));
        n_push1++;
      end
    end
  end

  logic [7:0] ops_y  [7] = '{8'h00, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00};
  logic       ops_z  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] bp_a   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] bp_b   [6] = '{8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'hAA, 8'h99};

  initial begin
    int idx;
    int start;
    int cyc;
    logic fired1;

    rst_n0 = 1'b0; in_valid0 = 1'b0; a0 = '0; b0 = '0; op0 = '0; out_ready0 = 1'b0;
    rst_n1 = 1'b0; in_valid1 = 1'b0; a1 = '0; b1 = '0; op1 = '0; out_ready1 = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready0), 1);
    check("rst_out_valid", 32'(out_valid0), 0);
    check("rst_y", 32'(y0), 0);
    check("rst_flags", {29'h0, y_zero0, y_parity0, y_err0}, 0);
    check("rst_acc", 32'(acc_count0), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    // All seven ops back to back, one per cycle.
    out_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        in_valid0 = 1'b1; a0 = 8'hC5; b0 = 8'h3A; op0 = 3'(i);
      end else begin
        in_valid0 = 1'b0;
      end
      @(negedge clk);
      if (i < 7) check("ops_in_ready", 32'(in_ready0), 1);
      @(posedge clk); #1;
      if (i == 0) begin
        check("ops_latency_not_yet", 32'(out_valid0), 0);
      end else begin
        check("ops_out_valid", 32'(out_valid0), 1);
        check("ops_y", 32'(y0), 32'(ops_y[i-1]));
        check("ops_zero", 32'(y_zero0), 32'(ops_z[i-1]));
        check("ops_parity", 32'(y_parity0), 0);
      end
    end

    // Illegal op followed by a legal AND.
    in_valid0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF; op0 = 3'd7;
    @(posedge clk); #1;
    op0 = 3'd0;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    check("ill_y", 32'(y0), 0);
    check("ill_err", 32'(y_err0), 1);
    check("ill_zero", 32'(y_zero0), 1);
    check("ill_parity", 32'(y_parity0), 0);
    check("ill_acc", 32'(acc_count0), 9);
    @(posedge clk); #1;
    check("after_ill_y", 32'(y0), 32'hFF);
    check("after_ill_err", 32'(y_err0), 0);
    check("after_ill_zero", 32'(y_zero0), 0);
    @(posedge clk); #1;

    // Backpressure: five cycles of offered input with the consumer stalled.
    out_ready0 = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid0 = 1'b1; a0 = bp_a[idx]; b0 = bp_b[idx]; op0 = 3'd5;
      @(negedge clk);
      if (in_ready0) idx++;
      @(posedge clk); #1;
      if (c >= 1) begin
        check("bp_out_valid", 32'(out_valid0), 1);
        check("bp_y_held", 32'(y0), 32'(bp_a[0] ^ bp_b[0]));
      end
    end
    check("bp_accepted", 32'(idx), 2);
    check("bp_in_ready_low", 32'(in_ready0), 0);
    check("bp_acc", 32'(acc_count0), 11);
    out_ready0 = 1'b1;
    cyc = 0;
    while (idx < 6 && cyc < 20) begin
      in_valid0 = 1'b1; a0 = bp_a[idx]; b0 = bp_b[idx]; op0 = 3'd5;
      @(negedge clk);
      check("bp_resume_ready", 32'(in_ready0), 1);
      if (in_ready0) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid0 = 1'b0;
    cyc = 0;
    while (q0.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_drained", 32'(q0.size()), 0);

    // Asynchronous reset with two transactions in flight.
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; a0 = 8'h5A; b0 = 8'h0F; op0 = 3'd1;
    @(posedge clk); #1;
    a0 = 8'hA5; op0 = 3'd3;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid0), 1);
    check("pre_rst_in_ready", 32'(in_ready0), 0);
    #1;
    rst_n0 = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid0), 0);
    check("mid_rst_y", 32'(y0), 0);
    check("mid_rst_flags", {29'h0, y_zero0, y_parity0, y_err0}, 0);
    check("mid_rst_acc", 32'(acc_count0), 0);
    check("mid_rst_in_ready", 32'(in_ready0), 1);
    q0.delete();
    @(posedge clk); #1;
    rst_n0 = 1'b1; out_ready0 = 1'b1;
    in_valid0 = 1'b1; a0 = 8'h0F; b0 = 8'hF0; op0 = 3'd1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready0), 1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    check("post_rst_acc", 32'(acc_count0), 1);
    check("post_rst_no_stale", 32'(out_valid0), 0);
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(out_valid0), 1);
    check("post_rst_y", 32'(y0), 32'hFF);
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_idle", 32'(out_valid0), 0);
    end

    // Counter saturation on the CNT_W=4 instance.
    out_ready1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid1 = 1'b1; a1 = 13'($urandom); b1 = 13'($urandom); op1 = 3'($urandom);
      @(posedge clk); #1;
      if (i == 14) check("sat_acc_15", 32'(acc_count1), 15);
    end
    in_valid1 = 1'b0;
    check("sat_acc_20", 32'(acc_count1), 15);
    repeat (3) @(posedge clk);
    #1;
    check("sat_acc_hold", 32'(acc_count1), 15);

    // Random stress: 50% valid, 50% ready, 10000 transactions.
    start = n_push1;
    fired1 = 1'b0;
    cyc = 0;
    while ((n_push1 - start) < 10000 && cyc < 80000) begin
      out_ready1 = 1'($urandom_range(0, 1));
      if (!in_valid1 || fired1) begin
        in_valid1 = 1'($urandom_range(0, 1));
        a1 = 13'($urandom); b1 = 13'($urandom); op1 = 3'($urandom);
      end
      @(negedge clk);
      fired1 = in_valid1 && in_ready1;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid1 = 1'b0;
    check("stress_count", 32'((n_push1 - start) >= 10000), 1);
    out_ready1 = 1'b1;
    cyc = 0;
    while (q1.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stress_drained", 32'(q1.size()), 0);
    check("stress_acc_sat", 32'(acc_count1), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
